// File: rtl/test_sequencer.sv
// Runs a bank of generated test methods through the req/busy/return handshake,
// applying a DUT reset and start delay first, and reports a single verdict.
module test_sequencer #(
    parameter int NUM_TESTS      = 4,
    parameter int RESET_CYCLES   = 6,
    parameter int START_DELAY    = 92,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int STOP_ON_FAIL   = 0,
    parameter int CNT_W          = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           dut_reset,
    output logic [NUM_TESTS-1:0]           test_req,
    input  logic [NUM_TESTS-1:0]           test_busy,
    input  logic [NUM_TESTS-1:0]           test_return,
    output logic [$clog2(NUM_TESTS):0]     cur_index,
    output logic                           done,
    output logic                           pass,
    output logic [NUM_TESTS-1:0]           fail_mask,
    output logic [NUM_TESTS-1:0]           timeout_mask,
    output logic [CNT_W-1:0]               cycle_count
);

    localparam int IDX_W = $clog2(NUM_TESTS) + 1;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TESTS - 1);
    localparam logic [31:0]          RST_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]          DLY_LAST = 32'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_TESTS-1:0] CH_ONE   = NUM_TESTS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_DELAY,
        S_REQ,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   dut_reset_q, dut_reset_d;
    logic [NUM_TESTS-1:0]   test_req_q, test_req_d;
    logic [IDX_W-1:0]       cur_index_q, cur_index_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [NUM_TESTS-1:0]   fail_mask_q, fail_mask_d;
    logic [NUM_TESTS-1:0]   timeout_mask_q, timeout_mask_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [31:0]            phase_cnt_q, phase_cnt_d;

    // One-hot select of the active channel; inactive channels are masked out.
    logic [NUM_TESTS-1:0]   chan_oh;
    logic                   busy_sel;
    logic                   ret_sel;
    logic                   tmo_hit;
    logic                   cur_bad;

    always_comb begin
        chan_oh  = CH_ONE << cur_index_q;
        busy_sel = |(test_busy & chan_oh);
        ret_sel  = |(test_return & chan_oh);
        tmo_hit  = (tmo_cnt_q == TMO_LAST);
        cur_bad  = |((fail_mask_q | timeout_mask_q) & chan_oh);
    end

    always_comb begin
        state_d        = state_q;
        dut_reset_d    = dut_reset_q;
        test_req_d     = test_req_q;
        cur_index_d    = cur_index_q;
        done_d         = done_q;
        pass_d         = pass_q;
        fail_mask_d    = fail_mask_q;
        timeout_mask_d = timeout_mask_q;
        cycle_count_d  = cycle_count_q;
        tmo_cnt_d      = tmo_cnt_q;
        phase_cnt_d    = phase_cnt_q;

        if (state_q != S_IDLE && state_q != S_DONE && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_RST;
                    dut_reset_d    = 1'b1;
                    test_req_d     = '0;
                    cur_index_d    = '0;
                    done_d         = 1'b0;
                    pass_d         = 1'b0;
                    fail_mask_d    = '0;
                    timeout_mask_d = '0;
                    cycle_count_d  = '0;
                    tmo_cnt_d      = '0;
                    phase_cnt_d    = '0;
                end
            end

            S_RST: begin
                if (phase_cnt_q == RST_LAST) begin
                    dut_reset_d = 1'b0;
                    phase_cnt_d = '0;
                    if (START_DELAY == 0) begin
                        state_d    = S_REQ;
                        test_req_d = chan_oh;
                        tmo_cnt_d  = '0;
                    end else begin
                        state_d = S_DELAY;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end

            S_DELAY: begin
                if (phase_cnt_q == DLY_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = S_REQ;
                    test_req_d  = chan_oh;
                    tmo_cnt_d   = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end

            S_REQ: begin
                if (tmo_hit) begin
                    timeout_mask_d = timeout_mask_q | chan_oh;
                    test_req_d     = '0;
                    state_d        = S_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    if (busy_sel) begin
                        state_d = S_RUN;
                    end
                end
            end

            // Request stays asserted while the method is busy.
            S_RUN: begin
                if (tmo_hit) begin
                    timeout_mask_d = timeout_mask_q | chan_oh;
                    test_req_d     = '0;
                    state_d        = S_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    if (!busy_sel) begin
                        if (!ret_sel) begin
                            fail_mask_d = fail_mask_q | chan_oh;
                        end
                        test_req_d = '0;
                        state_d    = S_NEXT;
                    end
                end
            end

            S_NEXT: begin
                tmo_cnt_d = '0;
                if (cur_index_q == LAST_IDX || (STOP_ON_FAIL != 0 && cur_bad)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = ((fail_mask_q | timeout_mask_q) == '0);
                end else begin
                    cur_index_d = cur_index_q + IDX_W'(1);
                    test_req_d  = chan_oh << 1;
                    state_d     = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            dut_reset_q    <= 1'b0;
            test_req_q     <= '0;
            cur_index_q    <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_mask_q    <= '0;
            timeout_mask_q <= '0;
            cycle_count_q  <= '0;
            tmo_cnt_q      <= '0;
            phase_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            dut_reset_q    <= dut_reset_d;
            test_req_q     <= test_req_d;
            cur_index_q    <= cur_index_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_mask_q    <= fail_mask_d;
            timeout_mask_q <= timeout_mask_d;
            cycle_count_q  <= cycle_count_d;
            tmo_cnt_q      <= tmo_cnt_d;
            phase_cnt_q    <= phase_cnt_d;
        end
    end

    assign dut_reset    = dut_reset_q;
    assign test_req     = test_req_q;
    assign cur_index    = cur_index_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_mask    = fail_mask_q;
    assign timeout_mask = timeout_mask_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: behavioural test-method models on each
// channel, one DUT running to completion and one halting at the first failure.
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_s = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  busy = 4'b0;
    logic [3:0]  ret = 4'b0;

    logic        rst_a, rst_s, done_a, done_s, pass_a, pass_s;
    logic [3:0]  req_a, req_s, fail_a, fail_s, tmo_a, tmo_s;
    logic [2:0]  cur_a, cur_s;
    logic [31:0] cyc_a, cyc_s;

    always #5 clk = ~clk;

    test_sequencer #(.NUM_TESTS(4), .RESET_CYCLES(6), .START_DELAY(92),
                     .TIMEOUT_CYCLES(50), .STOP_ON_FAIL(0), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_reset(rst_a),
        .test_req(req_a), .test_busy(busy), .test_return(ret),
        .cur_index(cur_a), .done(done_a), .pass(pass_a), .fail_mask(fail_a),
        .timeout_mask(tmo_a), .cycle_count(cyc_a));

    test_sequencer #(.NUM_TESTS(4), .RESET_CYCLES(6), .START_DELAY(92),
                     .TIMEOUT_CYCLES(50), .STOP_ON_FAIL(1), .CNT_W(32)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .dut_reset(rst_s),
        .test_req(req_s), .test_busy(busy), .test_return(ret),
        .cur_index(cur_s), .done(done_s), .pass(pass_s), .fail_mask(fail_s),
        .timeout_mask(tmo_s), .cycle_count(cyc_s));

    wire        m_rst  = sel ? rst_s  : rst_a;
    wire [3:0]  m_req  = sel ? req_s  : req_a;
    wire [2:0]  m_cur  = sel ? cur_s  : cur_a;
    wire        m_done = sel ? done_s : done_a;
    wire        m_pass = sel ? pass_s : pass_a;
    wire [3:0]  m_fail = sel ? fail_s : fail_a;
    wire [3:0]  m_tmo  = sel ? tmo_s  : tmo_a;
    wire [31:0] m_cyc  = sel ? cyc_s  : cyc_a;

    int checks = 0;
    int failures = 0;

    // Event records and channel models, all updated on the falling edge
    int ncyc = 0;
    int rst_rise = -1, done_rise = -1, first_req = -1;
    int rst_run = 0, rst_len = 0, req1_run = 0, req1_len = 0;
    int rise_q[$];
    bit onehot_bad = 1'b0;
    logic [3:0] prev_req = 4'b0;
    logic prev_rst = 1'b0, prev_done = 1'b0;
    logic [3:0] mode = 4'b0;      // 1 = channel never raises busy
    logic [3:0] retcfg = 4'hF;
    int cnt[4] = '{0, 0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (m_rst && !prev_rst) begin
                rst_rise = ncyc;
                rst_run = 0;
            end
            if (m_rst) begin
                rst_run++;
                rst_len = rst_run;
            end
            if (m_done && !prev_done) done_rise = ncyc;
            for (int i = 0; i < 4; i++) begin
                if (m_req[i] && !prev_req[i]) begin
                    if (rise_q.size() == 0) first_req = ncyc;
                    rise_q.push_back(i);
                end
            end
            if (m_req[1]) begin
                req1_run++;
                req1_len = req1_run;
            end else begin
                req1_run = 0;
            end
            if ($countones(m_req) > 1) onehot_bad = 1'b1;
            prev_req = m_req;
            prev_rst = m_rst;
            prev_done = m_done;
            // Busy rises one cycle after req, held 10 cycles, then return is presented.
            for (int i = 0; i < 4; i++) begin
                if (!m_req[i]) begin
                    cnt[i] = 0;
                    busy[i] = 1'b0;
                end else if (!mode[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) begin
                        busy[i] = 1'b1;
                    end else if (cnt[i] == 12) begin
                        busy[i] = 1'b0;
                        ret[i] = retcfg[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_rec();
        rise_q.delete();
        rst_rise = -1;
        done_rise = -1;
        first_req = -1;
        rst_len = 0;
        req1_len = 0;
        onehot_bad = 1'b0;
    endtask

    task automatic pulse_start(input bit use_s);
        if (use_s) start_s = 1'b1; else start_a = 1'b1;
        step(1);
        start_s = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && !m_done; k++) step(1);
        step(1);
        chk(tag, {63'b0, m_done}, 64'd1);
    endtask

    function automatic logic [63:0] rise_code();
        logic [63:0] c = 64'd0;
        foreach (rise_q[i]) c = (c << 4) | 64'(rise_q[i]);
        return c;
    endfunction

    initial begin
        // Reset state
        step(2);
        chk("reset_outputs", {47'b0, m_rst, m_req, m_cur, m_done, m_pass, m_fail, m_tmo}, 64'd0);
        chk("reset_cycles", {32'b0, m_cyc}, 64'd0);
        reset = 1'b0;
        step(2);

        // Run 1: all tests pass
        clear_rec();
        retcfg = 4'b1111;
        pulse_start(1'b0);
        chk("r1_rst_high", {63'b0, m_rst}, 64'd1);
        chk("r1_cyc_zero", {32'b0, m_cyc}, 64'd0);
        wait_done("r1_done");
        chk("r1_pass", {63'b0, m_pass}, 64'd1);
        chk("r1_masks", {56'b0, m_fail, m_tmo}, 64'd0);
        chk("r1_order", rise_code(), 64'h0123);
        chk("r1_nrise", 64'(rise_q.size()), 64'd4);
        chk("r1_onehot", {63'b0, onehot_bad}, 64'd0);
        chk("r1_rst_len", 64'(rst_len), 64'd6);
        chk("r1_first_req", 64'(first_req - rst_rise), 64'd98);
        chk("r1_done_time", 64'(done_rise - rst_rise), 64'd150);
        chk("r1_cycles", {32'b0, m_cyc}, 64'd150);
        chk("r1_cur", {61'b0, m_cur}, 64'd3);

        // Run 2, back to back: test 2 returns 0
        step(5);
        chk("r1_cyc_frozen", {32'b0, m_cyc}, 64'd150);
        clear_rec();
        retcfg = 4'b1011;
        pulse_start(1'b0);
        chk("r2_done_fell", {63'b0, m_done}, 64'd0);
        chk("r2_cleared", {55'b0, m_pass, m_fail, m_tmo}, 64'd0);
        chk("r2_cyc_restart", {32'b0, m_cyc}, 64'd0);
        wait_done("r2_done");
        chk("r2_fail", {60'b0, m_fail}, 64'b0100);
        chk("r2_tmo", {60'b0, m_tmo}, 64'd0);
        chk("r2_pass", {63'b0, m_pass}, 64'd0);
        chk("r2_order", rise_code(), 64'h0123);
        chk("r2_cur", {61'b0, m_cur}, 64'd3);
        chk("r2_cycles", {32'b0, m_cyc}, 64'd150);

        // Run 3: test 1 never raises busy and times out after 50 cycles
        clear_rec();
        retcfg = 4'b1111;
        mode = 4'b0010;
        pulse_start(1'b0);
        wait_done("r3_done");
        chk("r3_tmo", {60'b0, m_tmo}, 64'b0010);
        chk("r3_fail", {60'b0, m_fail}, 64'd0);
        chk("r3_pass", {63'b0, m_pass}, 64'd0);
        chk("r3_req1_len", 64'(req1_len), 64'd50);
        chk("r3_order", rise_code(), 64'h0123);
        chk("r3_done_time", 64'(done_rise - rst_rise), 64'd188);
        chk("r3_cycles", {32'b0, m_cyc}, 64'd188);
        mode = 4'b0000;

        // Run 4: asynchronous reset in the middle of test 2
        clear_rec();
        pulse_start(1'b0);
        for (int k = 0; k < 300 && !m_req[2]; k++) step(1);
        chk("r4_req2_seen", {63'b0, m_req[2]}, 64'd1);
        step(5);
        reset = 1'b1;
        #1;
        chk("r4_async_clear", {47'b0, m_rst, m_req, m_cur, m_done, m_pass, m_fail, m_tmo}, 64'd0);
        chk("r4_async_cyc", {32'b0, m_cyc}, 64'd0);
        start_a = 1'b1;
        step(2);
        start_a = 1'b0;
        chk("r4_start_ignored", {31'b0, m_rst, m_cyc}, 64'd0);
        reset = 1'b0;
        step(3);
        chk("r4_still_idle", {31'b0, m_rst, m_cyc}, 64'd0);
        clear_rec();
        pulse_start(1'b0);
        chk("r4_rst_high", {63'b0, m_rst}, 64'd1);
        wait_done("r4_done");
        chk("r4_rst_len", 64'(rst_len), 64'd6);
        chk("r4_pass", {63'b0, m_pass}, 64'd1);
        chk("r4_order", rise_code(), 64'h0123);
        chk("r4_cycles", {32'b0, m_cyc}, 64'd150);

        // Run 5: stop-on-fail instance, test 0 returns 0
        sel = 1'b1;
        step(1);
        clear_rec();
        retcfg = 4'b1110;
        pulse_start(1'b1);
        wait_done("r5_done");
        chk("r5_done_time", 64'(done_rise - rst_rise), 64'd111);
        chk("r5_cycles", {32'b0, m_cyc}, 64'd111);
        chk("r5_cur", {61'b0, m_cur}, 64'd0);
        chk("r5_fail", {60'b0, m_fail}, 64'b0001);
        chk("r5_tmo", {60'b0, m_tmo}, 64'd0);
        chk("r5_pass", {63'b0, m_pass}, 64'd0);
        chk("r5_nrise", 64'(rise_q.size()), 64'd1);
        step(10);
        chk("r5_no_more_req", {60'b0, m_req}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
